// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, state encoding and handshake constants for the
// multi-cycle integer divider, plus the operand magnitude helper.
package div_unit_pkg;

  localparam int DataBus       = 32;
  localparam int DoubleDataBus = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Magnitude of a two's complement operand when en is set. The most
  // negative value maps to itself, which is its correct unsigned magnitude.
  function automatic logic [DataBus-1:0] abs_val(input logic [DataBus-1:0] x,
                                                 input logic en);
    logic signed [DataBus-1:0] sx;
    sx = x;
    return (en && (sx < 0)) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: 32-cycle restoring divider for DIV/DIVU.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-low reset
//   start      - division request, held high until ready is seen
//   cancel     - abort (flush), overrides start
//   is_signed  - 1 = two's complement, 0 = unsigned; sampled in IDLE
//   operand_1  - dividend, sampled in IDLE
//   operand_2  - divisor, sampled in IDLE
//   ready      - registered result-valid flag
//   div_res    - {remainder, quotient}; zero whenever ready is low
module div_unit
  import div_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cancel,
  input  logic                     is_signed,
  input  logic [DataBus-1:0]       operand_1,
  input  logic [DataBus-1:0]       operand_2,
  output logic                     ready,
  output logic [DoubleDataBus-1:0] div_res
);

  div_state_e          state;
  logic [4:0]          cnt;
  // {partial remainder (33 bits), dividend/quotient (32 bits)}
  logic [64:0]         work;
  logic [DataBus-1:0]  divisor;
  logic                neg_q;
  logic                neg_r;

  logic [64:0]         shifted;
  logic [32:0]         trial;
  logic [64:0]         next_work;

  // Apply the sign correction to the unsigned {remainder, quotient}.
  function automatic logic [DoubleDataBus-1:0] fix_up(input logic [DoubleDataBus-1:0] raw,
                                                      input logic nq,
                                                      input logic nr);
    logic [DataBus-1:0] q;
    logic [DataBus-1:0] r;
    q = raw[DataBus-1:0];
    r = raw[DoubleDataBus-1:DataBus];
    if (nq) q = ~q + 1'b1;
    if (nr) r = ~r + 1'b1;
    return {r, q};
  endfunction

  // One restoring step. The partial remainder before the subtract is below
  // 2*divisor, so bit 32 of the 33-bit difference is exactly the borrow.
  always_comb begin
    shifted   = {work[63:0], 1'b0};
    trial     = shifted[64:32] - {1'b0, divisor};
    next_work = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= DivFree;
      cnt     <= '0;
      ready   <= DivResultNotReady;
      div_res <= '0;
    end else begin
      case (state)
        DivFree: begin
          ready   <= DivResultNotReady;
          div_res <= '0;
          if ((start == DivStart) && !cancel) begin
            if (operand_2 == '0) begin
              state <= DivByZero;
            end else begin
              state   <= DivOn;
              cnt     <= '0;
              neg_q   <= is_signed & (operand_1[31] ^ operand_2[31]);
              neg_r   <= is_signed & operand_1[31];
              work    <= {33'b0, abs_val(operand_1, is_signed)};
              divisor <= abs_val(operand_2, is_signed);
            end
          end
        end
        DivByZero: begin
          if (cancel) begin
            state <= DivFree;
          end else begin
            state   <= DivEnd;
            ready   <= DivResultReady;
            div_res <= '0;
          end
        end
        DivOn: begin
          if (cancel) begin
            state <= DivFree;
          end else begin
            work <= next_work;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state   <= DivEnd;
              ready   <= DivResultReady;
              div_res <= fix_up(next_work[63:0], neg_q, neg_r);
            end
          end
        end
        DivEnd: begin
          if ((start == DivStop) || cancel) begin
            state   <= DivFree;
            ready   <= DivResultNotReady;
            div_res <= '0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cancel;
  logic        is_signed;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        ready;
  logic [63:0] div_res;

  int errors = 0;
  int checks = 0;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cancel    (cancel),
    .is_signed (is_signed),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .ready     (ready),
    .div_res   (div_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Start a division at a falling edge, wait for ready with a bound, check
  // latency and result, then drop start and check the return to idle.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input string name);
    int lat;
    int zero_bad;
    @(negedge clk);
    start = 1'b1; is_signed = s; operand_1 = a; operand_2 = b;
    lat = 0;
    zero_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!ready && div_res != 64'd0) zero_bad++;
    end while (!ready && lat < 100);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, div_res, exp);
    check({name, " res zero while busy"}, 64'(zero_bad), 64'd0);
    start = 1'b0;
    @(negedge clk);
    check({name, " ready drop"}, {63'd0, ready}, 64'd0);
    check({name, " res clear"}, div_res, 64'd0);
  endtask

  task automatic watch_idle(input int n, input string name);
    int hits;
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (ready) hits++;
    end
    check(name, 64'(hits), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 33, "u100_7"};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "s-7_2"};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 33, "s7_-2"};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 33, "s_min_-1"};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h00000000, 32'hFFFFFFFF}, 33, "u_max_1"};
    vecs[5] = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'h00000001, 32'h7FFFFFFC}, 33, "u_big_2"};
    vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E}, 33, "s-100_-7"};
    vecs[7] = '{1'b0, 32'd5,          32'd9,          {32'h00000005, 32'h00000000}, 33, "u5_9"};
    vecs[8] = '{1'b0, 32'h12345678,   32'd0,          64'd0,                         2, "divzero"};

    rst = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
    operand_1 = '0; operand_2 = '0;
    repeat (3) @(negedge clk);
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset div_res", div_res, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++)
      do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

    // Divide by zero: result held while start stays high, cleared on drop.
    begin
      int lat;
      int lost;
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; operand_1 = 32'h12345678; operand_2 = 32'd0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!ready && lat < 20);
      check("dz hold latency", 64'(lat), 64'd2);
      lost = 0;
      repeat (5) begin
        @(negedge clk);
        if (!ready || div_res != 64'd0) lost++;
      end
      check("dz hold ready", 64'(lost), 64'd0);
      start = 1'b0;
      @(negedge clk);
      check("dz hold drop", {63'd0, ready}, 64'd0);
    end

    // Cancel while DONE with start still high returns to idle.
    begin
      int lat;
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; operand_1 = 32'd50; operand_2 = 32'd0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!ready && lat < 20);
      check("done cancel pre", {63'd0, ready}, 64'd1);
      cancel = 1'b1;
      @(negedge clk);
      check("done cancel ready", {63'd0, ready}, 64'd0);
      start = 1'b0; cancel = 1'b0;
      @(negedge clk);
    end

    // Cancel at cycle 10 of RUN: ready never asserts.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    watch_idle(40, "cancel run no ready");
    do_div(1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 33, "after cancel");

    // start and cancel together in IDLE: stay idle.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; operand_1 = 32'd9; operand_2 = 32'd3;
    watch_idle(40, "start+cancel idle");
    start = 1'b0; cancel = 1'b0;

    // Reset at cycle 20 of RUN.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; operand_1 = 32'hFFFFFFF9; operand_2 = 32'd2;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst ready", {63'd0, ready}, 64'd0);
    check("midrst div_res", div_res, 64'd0);
    rst = 1'b1; start = 1'b0;
    watch_idle(40, "midrst no ready");
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
